// File: rtl/mn_matrix_vec_mult.sv
// Row-by-row matrix-vector MAC: y = A*x or A'*x, reading A from mn_matrix and x from a local buffer.
// Latency: CHECK 1 cycle, then C+1 cycles per row (C fetch + 1 drain) before each result is offered.
// Backpressure: a result is held on o_y_data/o_y_index with o_out_valid until i_out_ready; no reads meanwhile.
module mn_matrix_vec_mult #(
  parameter int DATA_W    = 32,
  parameter int VEC_DEPTH = 16,
  parameter int ACC_W     = 72
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_vec_we,
  input  logic [$clog2(VEC_DEPTH)-1:0] i_vec_addr,
  input  logic signed [DATA_W-1:0] i_vec_data,
  input  logic                     i_start,
  input  logic [31:0]              i_m_dim,
  input  logic [31:0]              i_n_dim,
  input  logic                     i_transpose,
  output logic                     o_mat_read,
  output logic [31:0]              o_mat_m_addr,
  output logic [31:0]              o_mat_n_addr,
  output logic                     o_mat_transpose,
  input  logic signed [DATA_W-1:0] i_mat_data,
  output logic                     o_out_valid,
  input  logic                     i_out_ready,
  output logic [31:0]              o_y_index,
  output logic [DATA_W-1:0]        o_y_data,
  output logic                     o_busy,
  output logic                     o_done,
  output logic                     o_err
);

  localparam int VEC_AW = $clog2(VEC_DEPTH);
  localparam int CW     = VEC_AW + 1;
  localparam logic [31:0] DEPTH_W = 32'(VEC_DEPTH);
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_CHECK, S_FETCH, S_DRAIN, S_OUT, S_FIN} state_t;

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic [31:0]              r_m_dim;
  logic [31:0]              r_n_dim;
  logic                     r_transpose;
  logic                     r_err;
  logic [31:0]              r_r;
  logic [CW-1:0]            r_c;
  logic [VEC_AW-1:0]        r_c_prev;
  logic                     r_prod_vld;
  logic signed [ACC_W-1:0]  r_acc;
  logic [31:0]              r_m_hold;
  logic [31:0]              r_n_hold;
  logic signed [DATA_W-1:0] r_vec [VEC_DEPTH];

  logic [31:0]              w_rows;
  logic [31:0]              w_cols;
  logic                     w_dim_bad;
  logic [31:0]              w_c_ext;
  logic                     w_last_col;
  logic                     w_accept;
  logic [31:0]              w_r_nxt;
  logic signed [2*DATA_W-1:0] w_prod;
  logic signed [ACC_W-1:0]  w_prod_ext;
  logic [DATA_W-1:0]        w_sat;

  // Logical dimensions: transposing swaps the roles of the stored rows and columns.
  assign w_rows     = r_transpose ? r_n_dim : r_m_dim;
  assign w_cols     = r_transpose ? r_m_dim : r_n_dim;
  assign w_dim_bad  = (w_rows == 32'd0) || (w_cols == 32'd0) || (w_cols > DEPTH_W);
  assign w_c_ext    = {{(32-CW){1'b0}}, r_c};
  assign w_last_col = (w_c_ext == (w_cols - 32'd1));
  assign w_accept   = (r_state == S_OUT) && i_out_ready;
  assign w_r_nxt    = r_r + 32'd1;
  assign w_prod     = i_mat_data * r_vec[r_c_prev];
  assign w_prod_ext = {{(ACC_W-2*DATA_W){w_prod[2*DATA_W-1]}}, w_prod};

  // Clamp the wide accumulator into the signed output range.
  always_comb begin
    w_sat = r_acc[DATA_W-1:0];
    if (r_acc > SAT_MAX) begin
      w_sat = SAT_MAX[DATA_W-1:0];
    end else if (r_acc < SAT_MIN) begin
      w_sat = SAT_MIN[DATA_W-1:0];
    end
  end

  // State register.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (i_start) w_state_nxt = S_CHECK;
      S_CHECK: w_state_nxt = w_dim_bad ? S_FIN : S_FETCH;
      S_FETCH: if (w_last_col) w_state_nxt = S_DRAIN;
      S_DRAIN: w_state_nxt = S_OUT;
      S_OUT:   if (i_out_ready) w_state_nxt = (w_r_nxt == w_rows) ? S_FIN : S_FETCH;
      S_FIN:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs decoded from state; addresses hold their last fetched value outside FETCH.
  always_comb begin
    o_mat_read      = (r_state == S_FETCH);
    o_mat_m_addr    = (r_state == S_FETCH) ? r_r : r_m_hold;
    o_mat_n_addr    = (r_state == S_FETCH) ? w_c_ext : r_n_hold;
    o_mat_transpose = r_transpose;
    o_out_valid     = (r_state == S_OUT);
    o_y_index       = (r_state == S_OUT) ? r_r : 32'd0;
    o_y_data        = (r_state == S_OUT) ? w_sat : '0;
    o_busy          = (r_state != S_IDLE);
    o_done          = (r_state == S_FIN);
    o_err           = (r_state == S_FIN) && r_err;
  end

  // Job parameters are captured on an accepted start; the dimension verdict in CHECK.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_m_dim     <= 32'd0;
      r_n_dim     <= 32'd0;
      r_transpose <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      if ((r_state == S_IDLE) && i_start) begin
        r_m_dim     <= i_m_dim;
        r_n_dim     <= i_n_dim;
        r_transpose <= i_transpose;
      end
      if (r_state == S_CHECK) begin
        r_err <= w_dim_bad;
      end
    end
  end

  // Row/column counters and the address hold registers.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_r      <= 32'd0;
      r_c      <= '0;
      r_m_hold <= 32'd0;
      r_n_hold <= 32'd0;
    end else begin
      if (r_state == S_CHECK) begin
        r_r <= 32'd0;
        r_c <= '0;
      end else if (r_state == S_FETCH) begin
        r_c      <= r_c + 1'b1;
        r_m_hold <= r_r;
        r_n_hold <= w_c_ext;
      end else if (w_accept) begin
        r_r <= w_r_nxt;
        r_c <= '0;
      end
    end
  end

  // MAC pipeline: matrix data returns one cycle after its address, so pair it with the delayed column.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_c_prev   <= '0;
      r_prod_vld <= 1'b0;
      r_acc      <= '0;
    end else begin
      r_c_prev   <= r_c[VEC_AW-1:0];
      r_prod_vld <= (r_state == S_FETCH);
      if ((r_state == S_CHECK) || w_accept) begin
        r_acc <= '0;
      end else if (r_prod_vld) begin
        r_acc <= r_acc + w_prod_ext;
      end
    end
  end

  // Vector buffer: writable only while idle so a running job sees a frozen vector.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < VEC_DEPTH; i++) begin
        r_vec[i] <= '0;
      end
    end else if ((r_state == S_IDLE) && i_vec_we) begin
      r_vec[i_vec_addr] <= i_vec_data;
    end
  end

endmodule

// File: tb/tb_mn_matrix_vec_mult.sv
// Bench for mn_matrix_vec_mult: directed and random jobs against a plain-arithmetic model.
// Includes a behavioural mn_matrix (registered read, transpose-aware) feeding i_mat_data.
// Consumer drives i_out_ready, optionally stalling the first result.
module tb_mn_matrix_vec_mult;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_vec_we = 1'b0;
  logic [3:0]  i_vec_addr = '0;
  logic signed [31:0] i_vec_data = '0;
  logic        i_start = 1'b0;
  logic [31:0] i_m_dim = '0;
  logic [31:0] i_n_dim = '0;
  logic        i_transpose = 1'b0;
  logic        o_mat_read;
  logic [31:0] o_mat_m_addr;
  logic [31:0] o_mat_n_addr;
  logic        o_mat_transpose;
  logic signed [31:0] i_mat_data = '0;
  logic        o_out_valid;
  logic        i_out_ready = 1'b1;
  logic [31:0] o_y_index;
  logic [31:0] o_y_data;
  logic        o_busy;
  logic        o_done;
  logic        o_err;

  int n_checks = 0;
  int n_pass   = 0;

  int mat [20][20];
  int xm  [16];

  mn_matrix_vec_mult dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_vec_we(i_vec_we), .i_vec_addr(i_vec_addr), .i_vec_data(i_vec_data),
    .i_start(i_start), .i_m_dim(i_m_dim), .i_n_dim(i_n_dim), .i_transpose(i_transpose),
    .o_mat_read(o_mat_read), .o_mat_m_addr(o_mat_m_addr), .o_mat_n_addr(o_mat_n_addr),
    .o_mat_transpose(o_mat_transpose), .i_mat_data(i_mat_data),
    .o_out_valid(o_out_valid), .i_out_ready(i_out_ready),
    .o_y_index(o_y_index), .o_y_data(o_y_data),
    .o_busy(o_busy), .o_done(o_done), .o_err(o_err)
  );

  always #5 i_clk = ~i_clk;

  // Stored-matrix model: data appears one cycle after the address; transpose swaps the indices.
  always @(posedge i_clk) begin
    if (o_mat_read) begin
      if (o_mat_m_addr < 20 && o_mat_n_addr < 20)
        i_mat_data <= o_mat_transpose ? mat[o_mat_n_addr][o_mat_m_addr] : mat[o_mat_m_addr][o_mat_n_addr];
      else
        i_mat_data <= 32'hDEAD_BEEF;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(exp));
  endtask

  function automatic logic [63:0] sext(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  function automatic int rnd_elem();
    return int'($urandom_range(1048575, 0)) - 524288;
  endfunction

  // Reference: y[r] = sum_c A(r,c)*x[c], clamped to the 32-bit signed range.
  function automatic longint model_y(input int r, input int cols, input bit tr);
    longint s = 0;
    for (int c = 0; c < cols; c++)
      s += longint'(tr ? mat[c][r] : mat[r][c]) * longint'(xm[c]);
    if (s > 64'sd2147483647) s = 64'sd2147483647;
    if (s < -64'sd2147483648) s = -64'sd2147483648;
    return s;
  endfunction

  task automatic write_vec(input int idx, input int val);
    @(negedge i_clk);
    i_vec_we = 1'b1; i_vec_addr = idx[3:0]; i_vec_data = val;
    xm[idx] = val;
    @(negedge i_clk);
    i_vec_we = 1'b0;
  endtask

  task automatic outputs_zero(input string tag);
    chk({tag, "_mat_read"}, o_mat_read, 0);
    chk({tag, "_out_valid"}, o_out_valid, 0);
    chk({tag, "_busy"}, o_busy, 0);
    chk({tag, "_done"}, o_done, 0);
    chk({tag, "_err"}, o_err, 0);
    chk({tag, "_y_data"}, o_y_data, 0);
    chk({tag, "_m_addr"}, o_mat_m_addr, 0);
    chk({tag, "_n_addr"}, o_mat_n_addr, 0);
    chk({tag, "_mat_tr"}, o_mat_transpose, 0);
  endtask

  // One job: start, consume every row, check each result, read counts, transpose strobe and done/err.
  task automatic run_job(input int m, input int n, input bit tr, input int stall,
                         input bit poke, input bit wr_start, input int wr_idx, input int wr_val);
    int rows, cols, reads, row_reads, rows_out, hold, tr_bad;
    bit bad, seen_done;
    logic [31:0] y_held;
    rows = tr ? n : m;
    cols = tr ? m : n;
    bad  = (rows == 0) || (cols == 0) || (cols > 16);
    reads = 0; row_reads = 0; rows_out = 0; hold = 0; tr_bad = 0; seen_done = 0; y_held = '0;
    @(negedge i_clk);
    i_start = 1'b1; i_m_dim = m; i_n_dim = n; i_transpose = tr; i_out_ready = 1'b1;
    if (wr_start) begin
      i_vec_we = 1'b1; i_vec_addr = wr_idx[3:0]; i_vec_data = wr_val; xm[wr_idx] = wr_val;
    end
    for (int cyc = 1; cyc <= 3000 && !seen_done; cyc++) begin
      @(negedge i_clk);
      if (cyc == 1) begin
        i_start = 1'b0; i_vec_we = 1'b0;
        chk("busy_after_start", o_busy, 1);
      end
      if (poke && cyc == 4) begin
        i_vec_we = 1'b1; i_vec_addr = 4'd0; i_vec_data = 32'h5A5A; i_start = 1'b1; i_m_dim = 9;
      end
      if (poke && cyc == 5) begin
        i_vec_we = 1'b0; i_start = 1'b0;
      end
      if (o_mat_read) begin
        reads++; row_reads++;
        if (o_mat_transpose !== tr) tr_bad++;
      end
      if (o_out_valid) begin
        if (rows_out == 0 && hold < stall) begin
          i_out_ready = 1'b0;
          if (hold == 0) y_held = o_y_data;
          else chk("stall_y_stable", o_y_data, y_held);
          hold++;
        end else begin
          i_out_ready = 1'b1;
          chk("y_index", o_y_index, rows_out);
          chk("y_data", sext(o_y_data), model_y(rows_out, cols, tr));
          chk("reads_per_row", row_reads, cols);
          row_reads = 0;
          rows_out++;
        end
      end
      if (o_done) begin
        seen_done = 1'b1;
        chk("err_flag", o_err, bad);
        // Start cycle, CHECK, then FIN: done lands on the second edge after start is sampled.
        if (bad) chk("err_latency", cyc, 2);
      end
    end
    chk("done_seen", seen_done, 1);
    chk("rows_out", rows_out, bad ? 0 : rows);
    chk("total_reads", reads, bad ? 0 : rows * cols);
    chk("mat_transpose", tr_bad, 0);
    @(negedge i_clk);
    chk("busy_cleared", o_busy, 0);
  endtask

  initial begin
    int m, n, cols, found;
    bit tr;
    for (int i = 0; i < 20; i++)
      for (int j = 0; j < 20; j++)
        mat[i][j] = 0;
    for (int i = 0; i < 16; i++) xm[i] = 0;

    // Reset state.
    #1;
    outputs_zero("reset");
    repeat (2) @(negedge i_clk);
    i_reset = 1'b0;

    // A = [1 2 3; 4 5 6], x = [1 1 1] -> 6, 15.
    mat[0][0] = 1; mat[0][1] = 2; mat[0][2] = 3;
    mat[1][0] = 4; mat[1][1] = 5; mat[1][2] = 6;
    for (int i = 0; i < 3; i++) write_vec(i, 1);
    run_job(2, 3, 1'b0, 0, 1'b0, 1'b0, 0, 0);

    // Transposed with x = [1 2] -> 9, 12, 15.
    write_vec(0, 1); write_vec(1, 2);
    run_job(2, 3, 1'b1, 0, 1'b0, 1'b0, 0, 0);

    // First result stalled five cycles; start/vec_we mid-job are ignored.
    write_vec(0, 1); write_vec(1, 1); write_vec(2, 1);
    run_job(2, 3, 1'b0, 5, 1'b1, 1'b0, 0, 0);

    // Vector write coincident with start lands before the job uses it.
    run_job(2, 3, 1'b0, 0, 1'b0, 1'b1, 2, -7);

    // Saturation in both directions.
    mat[0][0] = 32'h7FFF_FFFF; mat[0][1] = 32'h7FFF_FFFF;
    write_vec(0, 2); write_vec(1, 2);
    run_job(1, 2, 1'b0, 0, 1'b0, 1'b0, 0, 0);
    write_vec(0, -2); write_vec(1, -2);
    run_job(1, 2, 1'b0, 0, 1'b0, 1'b0, 0, 0);

    // Bad dimensions.
    run_job(2, 0, 1'b0, 0, 1'b0, 1'b0, 0, 0);
    run_job(2, 17, 1'b0, 0, 1'b0, 1'b0, 0, 0);
    run_job(0, 3, 1'b0, 0, 1'b0, 1'b0, 0, 0);

    // Boundary: C = 16 is legal; 17 logical rows via transpose is legal.
    for (int i = 0; i < 20; i++)
      for (int j = 0; j < 20; j++)
        mat[i][j] = rnd_elem();
    for (int i = 0; i < 16; i++) write_vec(i, rnd_elem());
    run_job(2, 16, 1'b0, 0, 1'b0, 1'b0, 0, 0);
    run_job(2, 17, 1'b1, 0, 1'b0, 1'b0, 0, 0);

    // Random jobs.
    for (int k = 0; k < 6; k++) begin
      m = int'($urandom_range(5, 1));
      n = int'($urandom_range(5, 1));
      tr = 1'($urandom_range(1, 0));
      cols = tr ? m : n;
      for (int i = 0; i < 20; i++)
        for (int j = 0; j < 20; j++)
          mat[i][j] = rnd_elem();
      for (int i = 0; i < cols; i++) write_vec(i, rnd_elem());
      run_job(m, n, tr, int'($urandom_range(3, 0)), 1'b0, 1'b0, 0, 0);
    end

    // Reset during FETCH of row 1 aborts immediately; the vector buffer is cleared.
    mat[0][0] = 1; mat[0][1] = 2; mat[0][2] = 3;
    mat[1][0] = 4; mat[1][1] = 5; mat[1][2] = 6;
    for (int i = 0; i < 3; i++) write_vec(i, 1);
    @(negedge i_clk);
    i_start = 1'b1; i_m_dim = 2; i_n_dim = 3; i_transpose = 1'b0; i_out_ready = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    found = 0;
    for (int cyc = 0; cyc < 100 && found == 0; cyc++) begin
      if (o_mat_read && o_mat_m_addr == 32'd1) found = 1;
      else @(negedge i_clk);
    end
    chk("reached_row1_fetch", found, 1);
    #1 i_reset = 1'b1;
    #1;
    outputs_zero("midjob_reset");
    @(negedge i_clk);
    i_reset = 1'b0;
    for (int i = 0; i < 16; i++) xm[i] = 0;
    run_job(2, 3, 1'b0, 0, 1'b0, 1'b0, 0, 0);
    for (int i = 0; i < 3; i++) write_vec(i, 1);
    run_job(2, 3, 1'b0, 0, 1'b0, 1'b0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
